// File: rtl/lsu_pkg.sv
// lsu_pkg -- shared definitions for the byte-serial MIPS load/store unit.
//   * opcode constants for lb/lh/lw/lbu/lhu/sb/sh/sw
//   * FSM state enum
//   * decode_op(): opcode -> {supported, store, size in bytes, sign-extend}
package lsu_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       store;
    logic [2:0] size;  // bytes: 1, 2 or 4
    logic       sgn;
  } op_info_t;

  function automatic op_info_t decode_op(input logic [5:0] op);
    op_info_t d;
    d = '0;
    case (op)
      OP_LB:  begin d.valid = 1'b1; d.size = 3'd1; d.sgn = 1'b1; end
      OP_LH:  begin d.valid = 1'b1; d.size = 3'd2; d.sgn = 1'b1; end
      OP_LW:  begin d.valid = 1'b1; d.size = 3'd4; end
      OP_LBU: begin d.valid = 1'b1; d.size = 3'd1; end
      OP_LHU: begin d.valid = 1'b1; d.size = 3'd2; end
      OP_SB:  begin d.valid = 1'b1; d.size = 3'd1; d.store = 1'b1; end
      OP_SH:  begin d.valid = 1'b1; d.size = 3'd2; d.store = 1'b1; end
      OP_SW:  begin d.valid = 1'b1; d.size = 3'd4; d.store = 1'b1; end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// lsu_load_extend -- sign/zero extension of an assembled load value.
//   raw  : assembled big-endian value, loaded bytes in the low `size` bytes
//   size : access size in bytes (1, 2 or 4)
//   sgn  : 1 = sign-extend, 0 = zero-extend
//   ext  : 32-bit extended result
module lsu_load_extend (
  input  logic [31:0] raw,
  input  logic [2:0]  size,
  input  logic        sgn,
  output logic [31:0] ext
);

  always_comb begin
    ext = raw;
    case (size)
      3'd1:    ext = {{24{sgn & raw[7]}},  raw[7:0]};
      3'd2:    ext = {{16{sgn & raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit -- MIPS load/store unit driving a byte-wide memory port.
// One request at a time; words/halves are moved one byte per cycle, big-endian.
//   clk, rst_n            : clock, async active-low reset
//   req_valid/req_ready   : request handshake (ready only in IDLE)
//   opcode, addr, wdata   : request fields, sampled at accept
//   resp_valid            : one-cycle completion pulse
//   rdata, misalign, bad_op : response fields, zero outside the pulse
//   mem_addr/we/wdata/re  : byte memory port (read data returns next cycle)
//   mem_rdata             : byte read data
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        opcode,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              resp_valid,
  output logic [31:0]       rdata,
  output logic              misalign,
  output logic              bad_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata
);

  state_t      state;
  op_info_t    info_in;
  logic        aligned_in;
  logic [31:0] wdata_msb;   // store data left-justified so byte 0 sits in [31:24]
  logic [31:0] sdata_q;     // remaining store bytes, next one in [31:24]
  logic [23:0] ldata_q;     // load bytes captured so far
  logic [1:0]  cnt_q;
  logic [1:0]  last_q;      // index of final XFER cycle (N-1)
  logic [2:0]  size_q;
  logic        sgn_q;
  logic        store_q;
  logic [31:0] load_ext;
  logic        addr_hi_unused;

  assign addr_hi_unused = ^addr;
  assign req_ready      = (state == IDLE);

  always_comb begin
    info_in = decode_op(opcode);
    case (info_in.size)
      3'd2:    aligned_in = ~addr[0];
      3'd4:    aligned_in = (addr[1:0] == 2'b00);
      default: aligned_in = 1'b1;
    endcase
    case (info_in.size)
      3'd1:    wdata_msb = {wdata[7:0],  24'h0};
      3'd2:    wdata_msb = {wdata[15:0], 16'h0};
      default: wdata_msb = wdata;
    endcase
  end

  // The final load byte is on mem_rdata during DRAIN; extend it together
  // with the bytes already captured so rdata is registered at RESP entry.
  lsu_load_extend u_ext (
    .raw  ({ldata_q, mem_rdata}),
    .size (size_q),
    .sgn  (sgn_q),
    .ext  (load_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      rdata      <= '0;
      misalign   <= 1'b0;
      bad_op     <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      mem_wdata  <= '0;
      sdata_q    <= '0;
      ldata_q    <= '0;
      cnt_q      <= '0;
      last_q     <= '0;
      size_q     <= '0;
      sgn_q      <= 1'b0;
      store_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            size_q  <= info_in.size;
            sgn_q   <= info_in.sgn;
            store_q <= info_in.store;
            last_q  <= 2'(info_in.size - 3'd1);
            cnt_q   <= '0;
            ldata_q <= '0;
            if (!info_in.valid) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              bad_op     <= 1'b1;
            end else if (!aligned_in) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              misalign   <= 1'b1;
            end else begin
              state     <= XFER;
              mem_addr  <= addr[ADDR_W-1:0];
              mem_we    <= info_in.store;
              mem_re    <= ~info_in.store;
              mem_wdata <= info_in.store ? wdata_msb[31:24] : 8'h00;
              sdata_q   <= wdata_msb << 8;
            end
          end
        end
        XFER: begin
          // Byte k-1 of a load arrives during XFER cycle k (k >= 1).
          if (!store_q && cnt_q != 2'd0)
            ldata_q <= {ldata_q[15:0], mem_rdata};
          if (cnt_q == last_q) begin
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if (store_q) begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end else begin
            cnt_q     <= cnt_q + 2'd1;
            mem_addr  <= mem_addr + ADDR_W'(1);
            mem_wdata <= store_q ? sdata_q[31:24] : 8'h00;
            sdata_q   <= sdata_q << 8;
          end
        end
        DRAIN: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          rdata      <= load_ext;
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          rdata      <= '0;
          misalign   <= 1'b0;
          bad_op     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning width of the byte-port address to data memory.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  pipeline request strobe.
REQ-005 SHALL have port req_ready  output  1  high only in IDLE; the request is accepted when req_valid and req_ready are both high at a rising edge.
REQ-006 SHALL have port opcode  input  6  MIPS load/store opcode, sampled at accept.
REQ-007 SHALL have port addr  input  32  effective byte address (ALU result), sampled at accept.
REQ-008 SHALL have port wdata  input  32  store data (rt), sampled at accept.
REQ-009 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL have port rdata  output  32  extended load result, valid while resp_valid is high.
REQ-011 SHALL have port misalign  output  1  alignment fault, valid while resp_valid is high.
REQ-012 SHALL have port bad_op  output  1  unsupported opcode, valid while resp_valid is high.
REQ-013 SHALL have port mem_addr  output  ADDR_W  byte address to memory.
REQ-014 SHALL have port mem_we  output  1  byte write strobe; memory commits the byte at the rising edge.
REQ-015 SHALL have port mem_wdata  output  8  byte to write.
REQ-016 SHALL have port mem_re  output  1  byte read strobe; memory returns the byte on mem_rdata in the following cycle.
REQ-017 SHALL have port mem_rdata  input  8  read byte returned one cycle after mem_re.

Function
REQ-018 Opcodes and sizes SHALL be: lb 100000 (N=1, signed), lh 100001 (N=2, signed), lw 100011 (N=4), lbu 100100 (N=1, zero-extended), lhu 100101 (N=2, zero-extended), sb 101000 (N=1), sh 101001 (N=2), sw 101011 (N=4).
REQ-019 The FSM SHALL have states IDLE, XFER, DRAIN and RESP.
REQ-020 Transitions: IDLE->XFER on a valid aligned accept; XFER stays N cycles, one byte per cycle; XFER->DRAIN for loads and XFER->RESP for stores; DRAIN->RESP; RESP->IDLE.
REQ-021 On accept with addr mod N != 0, the FSM SHALL go IDLE->RESP with no memory strobe, misalign=1 and rdata=0.
REQ-022 On accept with an unsupported opcode, the FSM SHALL go IDLE->RESP with no memory strobe, bad_op=1 and rdata=0.
REQ-023 In XFER cycle k (k=0..N-1), mem_addr SHALL be addr[ADDR_W-1:0]+k; address bits above ADDR_W-1 are ignored.
REQ-024 Byte order SHALL be big-endian: byte k carries wdata bits [8(N-k)-1 : 8(N-k-1)].
REQ-025 Load bytes SHALL be captured one cycle after their mem_re; DRAIN captures the last byte.
REQ-026 The assembled load value SHALL be sign- or zero-extended to 32 bits per REQ-018.
REQ-027 Latency, counted from the accept edge: store SHALL assert resp_valid in cycle N+1; load in cycle N+2; fault responses in cycle 1.
REQ-028 A new request SHALL be acceptable in the cycle after RESP; req_valid held while busy SHALL be ignored, not queued.
REQ-029 Outside RESP, rdata, misalign and bad_op SHALL be 0.
REQ-030 mem_we and mem_re SHALL never be high in the same cycle and SHALL be low outside XFER.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, with req_ready=1, resp_valid=0, rdata=0, misalign=0, bad_op=0, mem_we=0, mem_re=0, mem_addr=0 and mem_wdata=0.
REQ-032 Reset during XFER or DRAIN SHALL abort the access with no response; store bytes already written remain in memory.

Structure
REQ-033 Package lsu_pkg SHALL hold the opcode constants, the state enum and the size/sign decode function.
REQ-034 The extension logic SHALL be one combinational sub-module, lsu_load_extend (inputs: assembled 32-bit value, N, signed flag).

Verification
REQ-035 sw addr=0x10 wdata=0xDEADBEEF -> mem_we in cycles 1-4 writing 0x10=DE, 0x11=AD, 0x12=BE, 0x13=EF; resp_valid in cycle 5.
REQ-036 Byte 0x20 = 0x80: lb -> rdata=0xFFFFFF80 in cycle 3; lbu -> rdata=0x00000080.
REQ-037 lh addr=0x21 -> no mem strobes; resp_valid cycle 1 with misalign=1, rdata=0. Opcode 000000 -> bad_op=1, cycle 1.
REQ-038 lw addr=0x000001FC with memory FC..FF = 12 34 56 78 -> mem_addr 0xFC..0xFF; rdata=0x12345678 in cycle 6.
REQ-039 sw with rst_n pulsed low in cycle 3 -> only bytes 0-1 written; no resp_valid; req_ready=1 during and after reset.
REQ-040 req_valid held high across two sb requests -> second accepted only in the cycle after the first RESP; no overlap of mem strobes.
